// File: rtl/qpu_exu_mres_wbck_pkg.sv
// ============================================================================
// Module   : qpu_exu_mres_wbck_pkg
// Brief    : Shared constants and state encoding for measurement-result writeback
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package qpu_exu_mres_wbck_pkg;

  localparam int QPU_QUBIT_NUM    = 8;
  localparam int QPU_MRES_TMO_CYC = 1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } mres_st_e;

endpackage

`default_nettype wire

// File: rtl/qpu_exu_mres_wbck_tmo_cnt.sv
// ============================================================================
// Module   : qpu_mres_tmo_cnt
// Brief    : COLLECT-phase cycle counter with terminal-count compare
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qpu_mres_tmo_cnt
  import qpu_exu_mres_wbck_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int TC_VAL = QPU_MRES_TMO_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] c_TC_LAST = CNT_W'(TC_VAL - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = i_inc && (r_cnt == c_TC_LAST);

endmodule

`default_nettype wire

// File: rtl/qpu_exu_mres_wbck.sv
// ============================================================================
// Module   : qpu_exu_mres_wbck
// Brief    : Collects MCU measurement beats for the OITF head entry and commits
//            them to QMR while popping OITF. Optional timeout: QPU_MRES_TIMEOUT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qpu_exu_mres_wbck
  import qpu_exu_mres_wbck_pkg::*;
#(
  parameter int QUBIT_NUM = QPU_QUBIT_NUM,
  parameter int TMO_W     = 16,
  parameter int TMO_CYC   = QPU_MRES_TMO_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 oitf_mf_vld,
  input  logic [QUBIT_NUM-1:0] oitf_ret_mf,
  output logic                 oitf_ret_qf_ena,
  input  logic                 mcu_i_vld,
  output logic                 mcu_i_rdy,
  input  logic [QUBIT_NUM-1:0] mcu_i_qmask,
  input  logic [QUBIT_NUM-1:0] mcu_i_res,
  output logic [QUBIT_NUM-1:0] qmr_wen,
  output logic [QUBIT_NUM-1:0] qmr_wdat,
  output logic                 mres_busy,
  output logic                 err_unexp,
  output logic                 err_tmo
);

  mres_st_e r_state;
  mres_st_e w_state_nxt;

  logic [QUBIT_NUM-1:0] r_pend;
  logic [QUBIT_NUM-1:0] r_got;
  logic [QUBIT_NUM-1:0] r_res;
  logic                 r_err_unexp;
  logic                 r_tmo_hit;

  logic                 w_in_idle;
  logic                 w_in_collect;
  logic                 w_in_commit;
  logic                 w_beat;
  logic [QUBIT_NUM-1:0] w_acc;
  logic [QUBIT_NUM-1:0] w_drop;
  logic [QUBIT_NUM-1:0] w_got_nxt;
  logic                 w_done;
  logic                 w_tmo_tc;
  logic                 w_latch;
  logic [QUBIT_NUM-1:0] w_wen;

  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_in_collect = (r_state == ST_COLLECT);
  assign w_in_commit  = (r_state == ST_COMMIT);
  assign w_latch      = w_in_idle && oitf_mf_vld;

  // Only qubits still owed by the head entry are taken; everything else is dropped.
  assign w_beat    = w_in_collect && mcu_i_vld;
  assign w_acc     = w_beat ? (mcu_i_qmask & r_pend & ~r_got) : '0;
  assign w_drop    = w_beat ? (mcu_i_qmask & ~w_acc) : '0;
  assign w_got_nxt = r_got | w_acc;
  assign w_done    = (w_got_nxt == r_pend);

`ifdef QPU_MRES_TIMEOUT_EN
  qpu_mres_tmo_cnt #(
    .CNT_W  (TMO_W),
    .TC_VAL (TMO_CYC)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_latch),
    .i_inc (w_in_collect),
    .o_tc  (w_tmo_tc)
  );
`else
  logic [TMO_W-1:0] w_unused_tmo_cfg;
  assign w_unused_tmo_cfg = TMO_W'(TMO_CYC);
  assign w_tmo_tc         = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (oitf_mf_vld) begin
          w_state_nxt = (oitf_ret_mf == '0) ? ST_COMMIT : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_done || w_tmo_tc) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= '0;
      r_got       <= '0;
      r_res       <= '0;
      r_err_unexp <= 1'b0;
      r_tmo_hit   <= 1'b0;
    end else begin
      r_err_unexp <= |w_drop;
      if (w_latch) begin
        r_pend    <= oitf_ret_mf;
        r_got     <= '0;
        r_res     <= '0;
        r_tmo_hit <= 1'b0;
      end else if (w_in_collect) begin
        // A beat landing on the timeout cycle still merges before the forced commit.
        r_got     <= w_got_nxt;
        r_res     <= (r_res & ~w_acc) | (mcu_i_res & w_acc);
        r_tmo_hit <= w_tmo_tc && !w_done;
      end
    end
  end

  assign w_wen = r_tmo_hit ? r_got : r_pend;

  assign mcu_i_rdy       = w_in_collect;
  assign oitf_ret_qf_ena = w_in_commit;
  assign qmr_wen         = w_in_commit ? w_wen : '0;
  assign qmr_wdat        = w_in_commit ? (r_res & w_wen) : '0;
  assign mres_busy       = !w_in_idle;
  assign err_unexp       = r_err_unexp;
  assign err_tmo         = w_in_commit && r_tmo_hit;

endmodule

`default_nettype wire

// File: doc/qpu_exu_mres_wbck.md
Name: qpu_exu_mres_wbck

Overview:
Measurement-result writeback stage. It sits directly downstream of the OITF measure FIFO and consumes the oldest outstanding measurement's qubit mask. It collects per-qubit results from the MCU over one or more beats, then commits them to the qubit measurement result register (QMR). In the same cycle it pops the OITF entry, which clears the matching qubit flags so stalled FMR/MEASURE instructions can dispatch.

Parameters:
QUBIT_NUM, `QPU_QUBIT_NUM (8), number of qubits / mask width
TMO_W, 16, timeout counter width
TMO_CYC, 1000, COLLECT cycles before forced commit (must be < 2^TMO_W)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, synchronous, active-high
oitf_mf_vld  in  1  OITF measure FIFO holds an entry
oitf_ret_mf  in  QUBIT_NUM  qubit mask of oldest outstanding measurement
oitf_ret_qf_ena  out  1  one-cycle pop / qubit-flag clear pulse to OITF
mcu_i_vld  in  1  MCU result beat valid
mcu_i_rdy  out  1  stage accepts a result beat
mcu_i_qmask  in  QUBIT_NUM  qubits carried by this beat
mcu_i_res  in  QUBIT_NUM  result bit per qubit (valid where qmask=1)
qmr_wen  out  QUBIT_NUM  per-qubit QMR write enable
qmr_wdat  out  QUBIT_NUM  per-qubit QMR write data
mres_busy  out  1  state != IDLE
err_unexp  out  1  one-cycle pulse: beat carried an unexpected or duplicate qubit
err_tmo  out  1  one-cycle pulse: forced commit on timeout

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; pend_r=0, got_r=0, res_r=0, tmo_cnt=0. All outputs are 0.
- Reset mid-operation: any partial collection is discarded with no commit and no pop. OITF is reset by the same `rst`.
- States:
  - IDLE: mcu_i_rdy=0. If oitf_mf_vld=1: latch pend_r<=oitf_ret_mf, clear got_r and res_r, then go to COLLECT. If oitf_ret_mf==0, go straight to COMMIT.
  - COLLECT: mcu_i_rdy=1. A beat is accepted when mcu_i_vld&mcu_i_rdy.
    - acc = mcu_i_qmask & pend_r & ~got_r.
    - res_r[j]<=mcu_i_res[j] where acc[j]=1.
    - got_r<=got_r|acc.
    - If mcu_i_qmask & ~acc is nonzero, those bits are dropped and err_unexp pulses in the next cycle.
    - If (got_r|acc)==pend_r, go to COMMIT.
  - COMMIT (exactly 1 cycle): mcu_i_rdy=0.
    - qmr_wen=pend_r and qmr_wdat=res_r&pend_r.
    - oitf_ret_qf_ena=1.
    - Next state is IDLE.
- Outputs are decoded from registered state only (Moore). There is no combinational path from mcu_i_* to oitf_ret_qf_ena or qmr_*.
- Latency:
  - Final beat accepted in cycle t → COMMIT/pop in t+1.
  - IDLE in t+2.
  - Next OITF entry latched in t+2 → COLLECT in t+3.
- oitf_ret_mf is sampled only in IDLE. It must remain the head entry until the pop, which is guaranteed because only this block pops.
- A beat with qmask=0 is accepted with no effect and no error.
- Only one measurement is in flight at a time. Results for the next entry are not accepted until COLLECT is re-entered.

Optional Feature:
Macro QPU_MRES_TIMEOUT_EN.
- Defined:
  - tmo_cnt clears on entry to COLLECT and increments each COLLECT cycle. It does not reset on beats.
  - When tmo_cnt==TMO_CYC-1 and the set is still incomplete, go to COMMIT with qmr_wen=got_r (only received qubits written) and oitf_ret_qf_ena=1.
  - err_tmo pulses during that COMMIT.
  - A beat accepted in the same cycle still merges into got_r/res_r first.
- Undefined: no counter. COLLECT waits indefinitely and err_tmo is tied to 0.

Decomposition:
- Shared defines go in QPU_defines.v:
  - `QPU_QUBIT_NUM.
  - `QPU_MRES_ST_IDLE/COLLECT/COMMIT as a 2-bit encoding.
  - `QPU_MRES_TMO_CYC default.
- Registers use the existing sirv_gnrl_dff* primitives wrapped for synchronous reset.
- One natural sub-module: qpu_mres_tmo_cnt (counter plus terminal-count compare), instantiated only under QPU_MRES_TIMEOUT_EN.

Test Plan:
- Single beat: oitf_ret_mf=8'h05, one beat qmask=8'h05 res=8'h04 → next cycle qmr_wen=8'h05, qmr_wdat=8'h04, oitf_ret_qf_ena=1 for 1 cycle, mres_busy drops a cycle later.
- Multi-beat: mask 8'h0F, beats qmask=8'h03 res=8'h01 then 8'h0C res=8'h08 → single commit qmr_wen=8'h0F, wdat=8'h09. No commit after the first beat.
- Unexpected and duplicate: mask 8'h01, beat qmask=8'h03 → bit0 accepted, err_unexp=1 one cycle later, commit wen=8'h01.
- Back-to-back entries: oitf_mf_vld held with masks 8'h01 then 8'h80 → two commits; mcu_i_rdy=0 during COMMIT/IDLE; second entry latched at t+2.
- Reset mid-COLLECT: rst=1 after a partial beat → IDLE, no oitf_ret_qf_ena, no qmr_wen, all outputs 0.
- Timeout (macro on, TMO_CYC=4): mask 8'h03, beat qmask=8'h01 only → commit after 4 COLLECT cycles with wen=8'h01, err_tmo=1, oitf_ret_qf_ena=1.
